// File: rtl/soc_pkg.sv
// Shared SoC definitions for the SDRAM bridge and the top-level address decoder.
//  - BridgeState        : bridge sequencer states
//  - SDRAM_WIN_BASE/MASK: SDRAM window decode constants (25-bit CPU address space)
//  - sdram_in_window()  : window decode helper
package soc_pkg;

    typedef enum logic [1:0] {
        BRIdle,
        BRPend,
        BRActive,
        BRDrain
    } BridgeState;

    localparam logic [24:0] SDRAM_WIN_BASE = 25'h080_0000;
    localparam logic [24:0] SDRAM_WIN_MASK = 25'h0F0_0000;

    function automatic logic sdram_in_window(input logic [24:0] addr,
                                             input logic [24:0] base,
                                             input logic [24:0] mask);
        return (addr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/sdram_bridge.sv
// sdram_bridge: FemtoRV32 memory bus to SDRAM controller valid/ready bridge.
// Decodes the SDRAM window, latches one request, sequences the controller handshake
// (PEND -> ACTIVE -> DRAIN), returns read data and holds the CPU busy until done.
// Any wait state that lasts TIMEOUT_CYCLES aborts the request and sets a sticky error.
//
// Ports:
//  clk, resetn              clock, asynchronous active-low reset
//  mem_addr/wdata/wmask     CPU request (wmask != 0 means write)
//  mem_rstrb                CPU read strobe
//  mem_rdata                read data returned to CPU
//  mem_rbusy, mem_wbusy     read / write in progress
//  sel                      combinational window hit
//  sdram_addr/din/wmask     latched request towards the controller
//  sdram_valid              request valid to controller
//  sdram_ready              controller busy flag (high while active)
//  sdram_dout               controller read data
//  timeout_err              sticky abort indicator
module sdram_bridge
    import soc_pkg::*;
#(
    parameter logic [24:0] SDRAM_BASE     = SDRAM_WIN_BASE,
    parameter logic [24:0] SDRAM_MASK     = SDRAM_WIN_MASK,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_rbusy,
    output logic        mem_wbusy,
    output logic        sel,
    output logic [24:0] sdram_addr,
    output logic [31:0] sdram_din,
    output logic [3:0]  sdram_wmask,
    output logic        sdram_valid,
    input  logic        sdram_ready,
    input  logic [31:0] sdram_dout,
    output logic        timeout_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] AbortData = 32'hDEAD_BEEF;

    BridgeState state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic rbusy_q, rbusy_d;
    logic wbusy_q, wbusy_d;
    logic valid_q, valid_d;
    logic [3:0] wmask_q, wmask_d;
    logic [24:0] addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic err_q, err_d;

    logic is_write;
    logic request;
    logic timed_out;

    // Upper CPU address bits are decoded outside this block.
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[31:25];

    assign sel       = sdram_in_window(mem_addr[24:0], SDRAM_BASE, SDRAM_MASK);
    assign is_write  = |mem_wmask;
    assign request   = sel & (mem_rstrb | is_write);
    assign timed_out = (cnt_q == CntLast);

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        rbusy_d = rbusy_q;
        wbusy_d = wbusy_q;
        valid_d = valid_q;
        wmask_d = wmask_q;
        addr_d  = addr_q;
        din_d   = din_q;
        err_d   = err_q;

        unique case (state_q)
            BRIdle: begin
                if (request) begin
                    addr_d  = {mem_addr[24:2], 2'b00};
                    din_d   = mem_wdata;
                    wmask_d = mem_wmask;  // zero for a read; a mixed strobe counts as write
                    rbusy_d = ~is_write;
                    wbusy_d = is_write;
                    state_d = BRPend;
                end
            end
            BRPend: begin
                if (!sdram_ready) begin
                    valid_d = 1'b1;
                    state_d = BRActive;
                end
            end
            BRActive: begin
                if (sdram_ready) begin
                    valid_d = 1'b0;
                    wmask_d = 4'b0000;
                    state_d = BRDrain;
                end
            end
            BRDrain: begin
                if (!sdram_ready) begin
                    if (rbusy_q) begin
                        rdata_d = sdram_dout;
                    end
                    rbusy_d = 1'b0;
                    wbusy_d = 1'b0;
                    state_d = BRIdle;
                end
            end
            default: state_d = BRIdle;
        endcase

        // Abort only when the awaited condition has not arrived in this same cycle.
        if (state_q != BRIdle && state_d == state_q && timed_out) begin
            valid_d = 1'b0;
            wmask_d = 4'b0000;
            if (rbusy_q) begin
                rdata_d = AbortData;
            end
            rbusy_d = 1'b0;
            wbusy_d = 1'b0;
            err_d   = 1'b1;
            state_d = BRIdle;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != BRIdle) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= BRIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
            rbusy_q <= 1'b0;
            wbusy_q <= 1'b0;
            valid_q <= 1'b0;
            wmask_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            rbusy_q <= rbusy_d;
            wbusy_q <= wbusy_d;
            valid_q <= valid_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            err_q   <= err_d;
        end
    end

    assign mem_rdata   = rdata_q;
    assign mem_rbusy   = rbusy_q;
    assign mem_wbusy   = wbusy_q;
    assign sdram_valid = valid_q;
    assign sdram_wmask = wmask_q;
    assign sdram_addr  = addr_q;
    assign sdram_din   = din_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_sdram_bridge.sv
// Directed testbench for sdram_bridge (TIMEOUT_CYCLES = 16).
module tb_sdram_bridge;

    logic        clk;
    logic        resetn;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic        mem_rbusy;
    logic        mem_wbusy;
    logic        sel;
    logic [24:0] sdram_addr;
    logic [31:0] sdram_din;
    logic [3:0]  sdram_wmask;
    logic        sdram_valid;
    logic        sdram_ready;
    logic [31:0] sdram_dout;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    sdram_bridge #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rstrb  (mem_rstrb),
        .mem_rdata  (mem_rdata),
        .mem_rbusy  (mem_rbusy),
        .mem_wbusy  (mem_wbusy),
        .sel        (sel),
        .sdram_addr (sdram_addr),
        .sdram_din  (sdram_din),
        .sdram_wmask(sdram_wmask),
        .sdram_valid(sdram_valid),
        .sdram_ready(sdram_ready),
        .sdram_dout (sdram_dout),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_read(input logic [31:0] addr);
        mem_addr  = addr;
        mem_rstrb = 1'b1;
        tick();
        mem_rstrb = 1'b0;
    endtask

    initial begin
        resetn      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wmask   = '0;
        mem_rstrb   = 1'b0;
        sdram_ready = 1'b0;
        sdram_dout  = '0;
        #12;
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_rbusy", 32'(mem_rbusy), 32'h0);
        check("rst_wbusy", 32'(mem_wbusy), 32'h0);
        check("rst_valid", 32'(sdram_valid), 32'h0);
        check("rst_wmask", 32'(sdram_wmask), 32'h0);
        check("rst_addr", 32'(sdram_addr), 32'h0);
        check("rst_din", sdram_din, 32'h0);
        check("rst_err", 32'(timeout_err), 32'h0);
        resetn = 1'b1;
        tick();

        // 1: read
        mem_addr  = 32'h0080_0010;
        mem_rstrb = 1'b1;
        #1;
        check("t1_sel", 32'(sel), 32'h1);
        tick();
        mem_rstrb = 1'b0;
        check("t1_rbusy_set", 32'(mem_rbusy), 32'h1);
        check("t1_valid_pend", 32'(sdram_valid), 32'h0);
        check("t1_addr", 32'(sdram_addr), 32'h0080_0010);
        check("t1_wmask", 32'(sdram_wmask), 32'h0);
        tick();
        check("t1_valid_act", 32'(sdram_valid), 32'h1);
        sdram_ready = 1'b1;
        sdram_dout  = 32'h1234_5678;
        tick();
        check("t1_valid_drain", 32'(sdram_valid), 32'h0);
        check("t1_rbusy_drain", 32'(mem_rbusy), 32'h1);
        sdram_ready = 1'b0;
        tick();
        check("t1_rbusy_clr", 32'(mem_rbusy), 32'h0);
        check("t1_rdata", mem_rdata, 32'h1234_5678);

        // 2: write
        mem_addr  = 32'h0080_0022;
        mem_wdata = 32'hCAFE_0000;
        mem_wmask = 4'b1100;
        sdram_dout = 32'h5555_5555;
        tick();
        mem_wmask = 4'b0000;
        check("t2_wbusy_set", 32'(mem_wbusy), 32'h1);
        check("t2_rbusy", 32'(mem_rbusy), 32'h0);
        check("t2_addr", 32'(sdram_addr), 32'h0080_0020);
        check("t2_din", sdram_din, 32'hCAFE_0000);
        tick();
        check("t2_valid", 32'(sdram_valid), 32'h1);
        check("t2_wmask_valid", 32'(sdram_wmask), 32'hC);
        sdram_ready = 1'b1;
        tick();
        check("t2_wmask_drain", 32'(sdram_wmask), 32'h0);
        sdram_ready = 1'b0;
        tick();
        check("t2_wbusy_clr", 32'(mem_wbusy), 32'h0);
        check("t2_rdata_kept", mem_rdata, 32'h1234_5678);

        // 3: out of window
        mem_addr  = 32'h0010_0000;
        mem_rstrb = 1'b1;
        #1;
        check("t3_sel", 32'(sel), 32'h0);
        tick();
        mem_rstrb = 1'b0;
        check("t3_rbusy", 32'(mem_rbusy), 32'h0);
        tick();
        check("t3_valid", 32'(sdram_valid), 32'h0);

        // 4: controller busy before strobe
        sdram_ready = 1'b1;
        repeat (5) tick();
        start_read(32'h0080_0040);
        check("t4_rbusy", 32'(mem_rbusy), 32'h1);
        tick();
        check("t4_pend_a", 32'(sdram_valid), 32'h0);
        tick();
        check("t4_pend_b", 32'(sdram_valid), 32'h0);
        sdram_ready = 1'b0;
        tick();
        check("t4_valid", 32'(sdram_valid), 32'h1);
        sdram_ready = 1'b1;
        sdram_dout  = 32'hA5A5_0001;
        tick();
        sdram_ready = 1'b0;
        tick();
        check("t4_rdata", mem_rdata, 32'hA5A5_0001);

        // 5: timeout in ACTIVE
        start_read(32'h0080_0100);
        tick();
        check("t5_valid", 32'(sdram_valid), 32'h1);
        repeat (15) tick();
        check("t5_still_act", 32'(sdram_valid), 32'h1);
        check("t5_no_err_yet", 32'(timeout_err), 32'h0);
        tick();
        check("t5_valid_abort", 32'(sdram_valid), 32'h0);
        check("t5_rbusy_abort", 32'(mem_rbusy), 32'h0);
        check("t5_rdata_abort", mem_rdata, 32'hDEAD_BEEF);
        check("t5_err", 32'(timeout_err), 32'h1);
        start_read(32'h0080_0104);
        tick();
        sdram_ready = 1'b1;
        sdram_dout  = 32'h0BAD_F00D;
        tick();
        sdram_ready = 1'b0;
        tick();
        check("t5_next_rdata", mem_rdata, 32'h0BAD_F00D);
        check("t5_err_sticky", 32'(timeout_err), 32'h1);

        // 6: async reset mid-ACTIVE
        start_read(32'h0080_0200);
        tick();
        check("t6_active", 32'(sdram_valid), 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        check("t6_valid", 32'(sdram_valid), 32'h0);
        check("t6_rbusy", 32'(mem_rbusy), 32'h0);
        check("t6_err", 32'(timeout_err), 32'h0);
        check("t6_rdata", mem_rdata, 32'h0);
        #3;
        resetn = 1'b1;
        tick();
        tick();
        check("t6_idle_valid", 32'(sdram_valid), 32'h0);
        check("t6_idle_rbusy", 32'(mem_rbusy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
